// File: rtl/riscv_wb_load_stage_pkg.sv
// Shared definitions for the load write-back stage: load size encoding and FSM states.
package riscv_wb_load_stage_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_WRITE = 2'd3
    } wb_state_e;

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load aligner: merges two beats, shifts by the byte offset, extends.
// Tag output present only when WB_LOAD_DIFT_TAG_EN is defined.
module riscv_load_align
    import riscv_wb_load_stage_pkg::*;
(
    input  logic [31:0] beat0,
    input  logic [31:0] beat1,
    input  logic [1:0]  data_type,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic        misaligned,
`ifdef WB_LOAD_DIFT_TAG_EN
    input  logic [3:0]  tag0,
    input  logic [3:0]  tag1,
    output logic        tag,
`endif
    output logic [31:0] result
);

    // One 64-bit right shift covers aligned extraction and both misaligned merges.
    logic [63:0] joined;
    logic [63:0] shifted;
    logic        unused_hi;

    assign joined    = misaligned ? {beat1, beat0} : {32'b0, beat0};
    assign shifted   = joined >> {offset, 3'b000};
    assign unused_hi = ^shifted[63:32];

    always_comb begin
        result = shifted[31:0];
        case (data_type)
            DT_BYTE: result = {{24{sign_ext & shifted[7]}},  shifted[7:0]};
            DT_HALF: result = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: result = shifted[31:0];
        endcase
    end

`ifdef WB_LOAD_DIFT_TAG_EN
    logic [7:0] tags;
    logic [7:0] tags_sh;
    logic [3:0] mask;
    logic       unused_tag_hi;

    assign tags          = misaligned ? {tag1, tag0} : {4'b0, tag0};
    assign tags_sh       = tags >> offset;
    assign unused_tag_hi = ^tags_sh[7:4];

    always_comb begin
        mask = 4'b1111;
        case (data_type)
            DT_BYTE: mask = 4'b0001;
            DT_HALF: mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
    end

    assign tag = |(tags_sh[3:0] & mask);
`endif

endmodule

// File: rtl/riscv_wb_load_stage.sv
// Load write-back stage: waits for memory beats, aligns, issues one registered regfile write.
// Optional taint tracking with WB_LOAD_DIFT_TAG_EN.
module riscv_wb_load_stage
    import riscv_wb_load_stage_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid_i,
    input  logic                      regfile_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] regfile_waddr_i,
    input  logic                      data_req_ex_i,
    input  logic [1:0]                data_type_i,
    input  logic                      data_sign_ext_i,
    input  logic [1:0]                data_addr_offset_i,
    input  logic                      data_misaligned_i,
    input  logic                      data_rvalid_i,
    input  logic [31:0]               data_rdata_i,
`ifdef WB_LOAD_DIFT_TAG_EN
    input  logic [3:0]                data_rdata_tag_i,
    output logic                      regfile_wdata_tag_o,
`endif
    output logic                      regfile_we_o,
    output logic [REG_ADDR_WIDTH-1:0] regfile_waddr_o,
    output logic [31:0]               regfile_wdata_o,
    output logic                      wb_ready_o,
    output logic                      err_o
);

    wb_state_e                 state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q;
    logic [1:0]                type_q;
    logic                      sign_q;
    logic [1:0]                off_q;
    logic                      mis_q;
    logic [31:0]               beat0_q;
    logic [31:0]               wdata_q;
    logic                      err_q;

    logic        accept, capture, take_beat0, load_res, err_d;
    logic        waiting, timeout;
    logic [31:0] align_beat0, align_res;

    assign accept  = ex_valid_i & regfile_we_i & data_req_ex_i;
    assign waiting = (state_q == ST_WAIT1) || (state_q == ST_WAIT2);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            logic [CNT_W-1:0] wdog_q;

            assign timeout = waiting && !data_rvalid_i
                             && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    wdog_q <= '0;
                else if (!waiting || data_rvalid_i || timeout)
                    wdog_q <= '0;
                else
                    wdog_q <= wdog_q + 1'b1;
            end
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        take_beat0 = 1'b0;
        load_res   = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = data_rvalid_i;
                if (accept) begin
                    capture = 1'b1;
                    state_d = ST_WAIT1;
                end
            end
            ST_WAIT1: begin
                if (data_rvalid_i) begin
                    if (mis_q) begin
                        take_beat0 = 1'b1;
                        state_d    = ST_WAIT2;
                    end else begin
                        load_res = 1'b1;
                        state_d  = ST_WRITE;
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT2: begin
                if (data_rvalid_i) begin
                    load_res = 1'b1;
                    state_d  = ST_WRITE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // a new load may be accepted while the previous one is being written
                err_d = data_rvalid_i;
                if (accept) begin
                    capture = 1'b1;
                    state_d = ST_WAIT1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign align_beat0 = (state_q == ST_WAIT2) ? beat0_q : data_rdata_i;

`ifdef WB_LOAD_DIFT_TAG_EN
    logic [3:0] tag0_q;
    logic       tag_q;
    logic       align_tag;
    logic [3:0] align_tag0;

    assign align_tag0 = (state_q == ST_WAIT2) ? tag0_q : data_rdata_tag_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag0_q <= '0;
            tag_q  <= 1'b0;
        end else begin
            if (take_beat0) tag0_q <= data_rdata_tag_i;
            if (load_res)   tag_q  <= align_tag;
        end
    end

    assign regfile_wdata_tag_o = tag_q;
`endif

    riscv_load_align u_align (
        .beat0      (align_beat0),
        .beat1      (data_rdata_i),
        .data_type  (type_q),
        .sign_ext   (sign_q),
        .offset     (off_q),
        .misaligned (mis_q),
`ifdef WB_LOAD_DIFT_TAG_EN
        .tag0       (align_tag0),
        .tag1       (data_rdata_tag_i),
        .tag        (align_tag),
`endif
        .result     (align_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            off_q   <= '0;
            mis_q   <= 1'b0;
            beat0_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (capture) begin
                waddr_q <= regfile_waddr_i;
                type_q  <= data_type_i;
                sign_q  <= data_sign_ext_i;
                off_q   <= data_addr_offset_i;
                mis_q   <= data_misaligned_i && (data_type_i != DT_BYTE);
            end
            if (take_beat0) beat0_q <= data_rdata_i;
            if (load_res)   wdata_q <= align_res;
        end
    end

    assign regfile_we_o    = (state_q == ST_WRITE);
    assign regfile_waddr_o = waddr_q;
    assign regfile_wdata_o = wdata_q;
    assign wb_ready_o      = (state_q == ST_IDLE) || (state_q == ST_WRITE);
    assign err_o           = err_q;

endmodule

// File: tb/tb_riscv_wb_load_stage.sv
// Directed bench for riscv_wb_load_stage: vector table of loads plus multi-cycle sequences.
module tb_riscv_wb_load_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, regfile_we = 1'b0, data_req_ex = 1'b0;
    logic [4:0]  regfile_waddr = '0;
    logic [1:0]  data_type = '0, data_addr_offset = '0;
    logic        data_sign_ext = 1'b0, data_misaligned = 1'b0;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        we_o, ready_o, err_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
`ifdef WB_LOAD_DIFT_TAG_EN
    logic [3:0]  data_rdata_tag = '0;
    logic        wdata_tag_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_wb_load_stage #(.REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_valid_i         (ex_valid),
        .regfile_we_i       (regfile_we),
        .regfile_waddr_i    (regfile_waddr),
        .data_req_ex_i      (data_req_ex),
        .data_type_i        (data_type),
        .data_sign_ext_i    (data_sign_ext),
        .data_addr_offset_i (data_addr_offset),
        .data_misaligned_i  (data_misaligned),
        .data_rvalid_i      (data_rvalid),
        .data_rdata_i       (data_rdata),
`ifdef WB_LOAD_DIFT_TAG_EN
        .data_rdata_tag_i   (data_rdata_tag),
        .regfile_wdata_tag_o(wdata_tag_o),
`endif
        .regfile_we_o       (we_o),
        .regfile_waddr_o    (waddr_o),
        .regfile_wdata_o    (wdata_o),
        .wb_ready_o         (ready_o),
        .err_o              (err_o)
    );

    typedef struct {
        logic [1:0]  dtype;
        logic        sign;
        logic [1:0]  off;
        logic        mis;
        logic [31:0] b0;
        logic [31:0] b1;
        logic [4:0]  waddr;
        int          dly;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic handover(input logic [1:0] t, input logic s, input logic [1:0] o,
                            input logic m, input logic [4:0] a);
        ex_valid         = 1'b1;
        regfile_we       = 1'b1;
        data_req_ex      = 1'b1;
        data_type        = t;
        data_sign_ext    = s;
        data_addr_offset = o;
        data_misaligned  = m;
        regfile_waddr    = a;
    endtask

    task automatic no_handover();
        ex_valid    = 1'b0;
        regfile_we  = 1'b0;
        data_req_ex = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        chk($sformatf("v%0d ready_idle", idx), ready_o, 1'b1);
        handover(v.dtype, v.sign, v.off, v.mis, v.waddr);
        step();
        no_handover();
        chk($sformatf("v%0d ready_wait", idx), ready_o, 1'b0);
        repeat (v.dly - 1) begin
            chk($sformatf("v%0d no_we_wait", idx), we_o, 1'b0);
            step();
        end
        data_rvalid = 1'b1;
        data_rdata  = v.b0;
        step();
        if (v.mis && v.dtype != 2'b00) begin
            chk($sformatf("v%0d no_we_beat0", idx), we_o, 1'b0);
            data_rdata = v.b1;
            step();
        end
        data_rvalid = 1'b0;
        chk($sformatf("v%0d we", idx), we_o, 1'b1);
        chk($sformatf("v%0d waddr", idx), waddr_o, v.waddr);
        chk($sformatf("v%0d wdata", idx), wdata_o, v.exp);
        chk($sformatf("v%0d ready_write", idx), ready_o, 1'b1);
        step();
        chk($sformatf("v%0d we_drop", idx), we_o, 1'b0);
        chk($sformatf("v%0d err", idx), err_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //             type   sgn  off  mis  beat0         beat1         waddr dly expected
        vecs[0]  = '{2'b10, 1'b0, 2'd0, 1'b0, 32'hDEADBEEF, 32'h00000000, 5'd5,  3, 32'hDEADBEEF};
        vecs[1]  = '{2'b00, 1'b1, 2'd2, 1'b0, 32'h12805634, 32'h00000000, 5'd6,  1, 32'hFFFFFF80};
        vecs[2]  = '{2'b00, 1'b0, 2'd2, 1'b0, 32'h12805634, 32'h00000000, 5'd7,  2, 32'h00000080};
        vecs[3]  = '{2'b10, 1'b0, 2'd1, 1'b1, 32'h44332211, 32'h88776655, 5'd8,  1, 32'h55443322};
        vecs[4]  = '{2'b01, 1'b1, 2'd3, 1'b1, 32'hAB000000, 32'h000000F0, 5'd9,  2, 32'hFFFFF0AB};
        vecs[5]  = '{2'b01, 1'b0, 2'd2, 1'b0, 32'hBEEF1234, 32'h00000000, 5'd10, 1, 32'h0000BEEF};
        vecs[6]  = '{2'b01, 1'b1, 2'd0, 1'b0, 32'h00017FFF, 32'h00000000, 5'd11, 1, 32'h00007FFF};
        vecs[7]  = '{2'b00, 1'b1, 2'd3, 1'b1, 32'h9A000000, 32'h00000000, 5'd12, 1, 32'hFFFFFF9A};
        vecs[8]  = '{2'b11, 1'b1, 2'd0, 1'b0, 32'hCAFEF00D, 32'h00000000, 5'd13, 1, 32'hCAFEF00D};
        vecs[9]  = '{2'b10, 1'b0, 2'd3, 1'b1, 32'hAABBCCDD, 32'h11223344, 5'd14, 3, 32'h223344AA};
        vecs[10] = '{2'b10, 1'b1, 2'd2, 1'b1, 32'h55667788, 32'h11223344, 5'd15, 1, 32'h33445566};
        vecs[11] = '{2'b00, 1'b0, 2'd1, 1'b0, 32'h0000FF00, 32'h00000000, 5'd31, 2, 32'h000000FF};

        // reset values
        #3;
        chk("rst we", we_o, 1'b0);
        chk("rst waddr", waddr_o, 5'd0);
        chk("rst wdata", wdata_o, 32'h0);
        chk("rst ready", ready_o, 1'b1);
        chk("rst err", err_o, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) run_vec(i);

        // back-to-back: second handover in the WRITE cycle of the first
        handover(2'b10, 1'b0, 2'd0, 1'b0, 5'd7);
        step();
        no_handover();
        data_rvalid = 1'b1;
        data_rdata  = 32'h11111111;
        step();
        data_rvalid = 1'b0;
        chk("b2b we0", we_o, 1'b1);
        chk("b2b waddr0", waddr_o, 5'd7);
        chk("b2b wdata0", wdata_o, 32'h11111111);
        handover(2'b00, 1'b0, 2'd0, 1'b0, 5'd9);
        step();
        no_handover();
        chk("b2b gap_we", we_o, 1'b0);
        chk("b2b gap_ready", ready_o, 1'b0);
        data_rvalid = 1'b1;
        data_rdata  = 32'h000000AB;
        step();
        data_rvalid = 1'b0;
        chk("b2b we1", we_o, 1'b1);
        chk("b2b waddr1", waddr_o, 5'd9);
        chk("b2b wdata1", wdata_o, 32'h000000AB);
        step();
        chk("b2b idle_we", we_o, 1'b0);

        // non-load handover is ignored
        ex_valid = 1'b1; regfile_we = 1'b1; data_req_ex = 1'b0; regfile_waddr = 5'd3;
        step();
        no_handover();
        chk("nonload ready", ready_o, 1'b1);

        // stray rvalid in IDLE
        data_rvalid = 1'b1;
        data_rdata  = 32'h12345678;
        step();
        data_rvalid = 1'b0;
        chk("stray err", err_o, 1'b1);
        chk("stray we", we_o, 1'b0);
        step();
        chk("stray err_drop", err_o, 1'b0);
        chk("stray we_after", we_o, 1'b0);

        // watchdog with TIMEOUT_CYCLES=4
        handover(2'b10, 1'b0, 2'd0, 1'b0, 5'd20);
        step();
        no_handover();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wdog wait%0d err", c), err_o, 1'b0);
            chk($sformatf("wdog wait%0d ready", c), ready_o, 1'b0);
            step();
        end
        chk("wdog err", err_o, 1'b1);
        chk("wdog we", we_o, 1'b0);
        chk("wdog ready", ready_o, 1'b1);
        step();
        chk("wdog err_drop", err_o, 1'b0);
        chk("wdog no_we", we_o, 1'b0);

        // reset while waiting for the second beat
        handover(2'b10, 1'b0, 2'd1, 1'b1, 5'd21);
        step();
        no_handover();
        data_rvalid = 1'b1;
        data_rdata  = 32'hA5A5A5A5;
        step();
        data_rvalid = 1'b0;
        chk("wait2 ready", ready_o, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst we", we_o, 1'b0);
        chk("midrst ready", ready_o, 1'b1);
        chk("midrst waddr", waddr_o, 5'd0);
        chk("midrst wdata", wdata_o, 32'h0);
        chk("midrst err", err_o, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk("postrst we", we_o, 1'b0);
        chk("postrst ready", ready_o, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
